// File: rtl/act_skew_feeder_if.sv
// Activation stream into the skew feeder and skewed per-row outputs to the PE array.
// The feeder sits on the slave side. The producer and the array-side observer sit on the master side.
interface act_skew_feeder_if #(
  parameter int ARRAY_ROWS = 4,
  parameter int ACT_WIDTH  = 8
);
  logic                            in_valid;
  logic                            in_ready;
  logic [ARRAY_ROWS*ACT_WIDTH-1:0] in_act;
  logic [ARRAY_ROWS*ACT_WIDTH-1:0] act_out;
  logic [ARRAY_ROWS*3-1:0]         op_out;
  logic [ARRAY_ROWS-1:0]           lane_valid;

  modport master (
    output in_valid, in_act,
    input  in_ready, act_out, op_out, lane_valid
  );

  modport slave (
    input  in_valid, in_act,
    output in_ready, act_out, op_out, lane_valid
  );
endinterface

// File: rtl/act_skew_feeder.sv
// Skews ARRAY_ROWS-wide activation vectors into a systolic wavefront; row r has r+1 cycles of latency.
// in_ready is high only in FEED; a cycle without in_valid becomes a zero bubble that keeps the skew aligned.
module act_skew_feeder #(
  parameter int ARRAY_ROWS = 4,
  parameter int ACT_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 os_mode,
  input  logic [CNT_WIDTH-1:0] vec_count,
  act_skew_feeder_if.slave     bus,
  output logic                 busy,
  output logic                 done
);

  localparam int FW = (ARRAY_ROWS > 2) ? $clog2(ARRAY_ROWS - 1) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((ARRAY_ROWS > 1) ? ARRAY_ROWS - 2 : 0);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, vec_q, vec_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [FW-1:0]        flush_q, flush_d;
  logic                 os_q, os_d;
  logic                 accept;

  assign bus.in_ready = (state_q == FEED);
  assign accept       = bus.in_valid && (state_q == FEED);
  assign cnt_inc      = cnt_q + 1'b1;
  assign busy         = (state_q == FEED) || (state_q == FLUSH);
  assign done         = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      flush_q <= '0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      flush_q <= flush_d;
      os_q    <= os_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    os_d    = os_q;
    flush_d = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          vec_d   = vec_count;
          os_d    = os_mode;
          cnt_d   = '0;
          state_d = (vec_count == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == vec_q) state_d = (ARRAY_ROWS == 1) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (flush_q == FLUSH_LAST) state_d = DONE;
        else                       flush_d = flush_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Chains shift every cycle; outside an accept they take in zero data with a
  // clear valid bit, so the tail drains to zero through FLUSH and DONE.
  for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_lane
    logic [ACT_WIDTH-1:0] dat_q [r+1];
    logic [r:0]           vld_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int d = 0; d <= r; d++) dat_q[d] <= '0;
        vld_q <= '0;
      end else begin
        dat_q[0] <= accept ? bus.in_act[r*ACT_WIDTH +: ACT_WIDTH] : '0;
        vld_q[0] <= accept;
        for (int d = 1; d <= r; d++) begin
          dat_q[d] <= dat_q[d-1];
          vld_q[d] <= vld_q[d-1];
        end
      end
    end

    assign bus.act_out[r*ACT_WIDTH +: ACT_WIDTH] = dat_q[r];
    assign bus.lane_valid[r]                     = vld_q[r];
    // A zero activation under accumulate leaves an OS partial sum untouched.
    assign bus.op_out[r*3 +: 3] = ((state_q != IDLE) && os_q) ? 3'b100 : 3'b000;
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Scoreboard bench for act_skew_feeder: the driver queues per-lane expectations, and a negedge monitor pops and compares them.
module tb_act_skew_feeder;
  localparam int R  = 4;
  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, start, os_mode;
  logic [CW-1:0] vec_count;
  logic          busy, done;

  act_skew_feeder_if #(.ARRAY_ROWS(R), .ACT_WIDTH(W)) bus();

  act_skew_feeder #(.ARRAY_ROWS(R), .ACT_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .os_mode   (os_mode),
    .vec_count (vec_count),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] dat;
    logic [2:0]   op;
    int           cyc;
  } exp_t;

  exp_t lane_q [R][$];
  int   done_q [$];
  int   checks = 0;
  int   errors = 0;
  logic cur_os = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every valid lane beat and every done pulse must match a queued expectation.
  initial begin
    exp_t e;
    int   dc;
    forever begin
      @(negedge clk);
      for (int r = 0; r < R; r++) begin
        if (bus.lane_valid[r] === 1'b1) begin
          if (lane_q[r].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lane%0d_unexpected actual=%0h expected=no_beat", r, bus.act_out[r*W +: W]);
          end else begin
            e = lane_q[r].pop_front();
            chk($sformatf("lane%0d_dat", r), 64'(bus.act_out[r*W +: W]), 64'(e.dat));
            chk($sformatf("lane%0d_op", r), 64'(bus.op_out[r*3 +: 3]), 64'(e.op));
            chk($sformatf("lane%0d_cycle", r), 64'(cyc), 64'(e.cyc));
          end
        end else begin
          chk($sformatf("lane%0d_idle_zero", r), 64'(bus.act_out[r*W +: W]), 64'd0);
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected actual=1 expected=0 at cycle %0d", cyc);
        end else begin
          dc = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(dc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_start(input logic os, input logic [CW-1:0] n);
    start     = 1'b1;
    os_mode   = os;
    vec_count = n;
    cur_os    = os;
    tick();
    start = 1'b0;
    if (n == '0) done_q.push_back(cyc);
  endtask

  task automatic send(input logic [R*W-1:0] v, input bit last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_act   = v;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept of %0h", v);
      bus.in_valid = 1'b0;
      return;
    end
    tick();
    for (int r = 0; r < R; r++)
      lane_q[r].push_back('{v[r*W +: W], (cur_os ? 3'b100 : 3'b000), cyc + r});
    if (last) done_q.push_back(cyc + R - 1);
    bus.in_valid = 1'b0;
    bus.in_act   = '0;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_act_out"},    64'(bus.act_out),    64'd0);
    chk({tag, "_op_out"},     64'(bus.op_out),     64'd0);
    chk({tag, "_lane_valid"}, 64'(bus.lane_valid), 64'd0);
    chk({tag, "_in_ready"},   64'(bus.in_ready),   64'd0);
    chk({tag, "_busy"},       64'(busy),           64'd0);
    chk({tag, "_done"},       64'(done),           64'd0);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    reset        = 1'b1;
    start        = 1'b0;
    os_mode      = 1'b0;
    vec_count    = '0;
    bus.in_valid = 1'b1;
    bus.in_act   = 32'hDEADBEEF;
    repeat (2) tick();
    chk_all_quiet("reset");
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_act   = '0;
    tick();

    // Basic WS tile: two back-to-back vectors.
    do_start(1'b0, 16'd2);
    chk("ws_feed_ready", 64'(bus.in_ready), 64'd1);
    chk("ws_feed_busy",  64'(busy),         64'd1);
    send(32'h04030201, 1'b0);
    send(32'h08070605, 1'b1);
    idle(8);
    chk("ws_after_op",    64'(bus.op_out),   64'd0);
    chk("ws_after_ready", 64'(bus.in_ready), 64'd0);
    chk("ws_after_busy",  64'(busy),         64'd0);

    // Two bubbles between the vectors: FEED must hold until the second accept.
    do_start(1'b0, 16'd2);
    send(32'h44332211, 1'b0);
    tick();
    chk("bubble1_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("bubble2_ready", 64'(bus.in_ready), 64'd1);
    send(32'h88776655, 1'b1);
    idle(8);

    // OS tile, then an empty tile.
    do_start(1'b1, 16'd3);
    send(32'h0A090807, 1'b0);
    send(32'h1A191817, 1'b0);
    send(32'h2A292827, 1'b1);
    idle(8);
    chk("os_idle_op", 64'(bus.op_out), 64'd0);
    do_start(1'b0, 16'd0);
    seen = bus.in_ready;
    repeat (3) begin
      tick();
      seen = seen | bus.in_ready;
    end
    chk("zero_tile_ready_seen", 64'(seen), 64'd0);
    idle(2);

    // Reset during FLUSH aborts the tile: no further beats and no done.
    do_start(1'b0, 16'd1);
    send(32'hA1B2C3D4, 1'b1);
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b1;
    for (int r = 0; r < R; r++) lane_q[r].delete();
    done_q.delete();
    tick();
    chk_all_quiet("abort");
    reset = 1'b0;
    idle(6);
    do_start(1'b0, 16'd1);
    send(32'h0F0E0D0C, 1'b1);
    idle(8);

    // A start pulse during FEED must not re-latch vec_count or os_mode.
    do_start(1'b0, 16'd3);
    send(32'h13121110, 1'b0);
    start     = 1'b1;
    vec_count = 16'd2;
    os_mode   = 1'b1;
    tick();
    start   = 1'b0;
    os_mode = 1'b0;
    chk("busy_start_ignored_ready", 64'(bus.in_ready), 64'd1);
    send(32'h23222120, 1'b0);
    send(32'h33323130, 1'b1);
    idle(8);

    for (int r = 0; r < R; r++)
      chk($sformatf("lane%0d_drained", r), 64'(lane_q[r].size()), 64'd0);
    chk("done_drained", 64'(done_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
